// File: rtl/serial_frame_tx.sv
// Buffered serial transmitter: host fills a byte buffer, then shifts the frame out
// LSB-first at DIV clocks per bit, either raw or UART-framed (start/stop per byte).
module serial_frame_tx #(
    parameter int BYTES  = 6,
    parameter int SEL_W  = 3,
    parameter int DIV    = 4,
    parameter int FRAMED = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data,
    input  logic [SEL_W-1:0] sel,
    input  logic             get,
    input  logic [SEL_W:0]   len,
    input  logic             send,
    output logic             tx,
    output logic             busy,
    output logic             done,
    output logic             load_err
);

    localparam int              DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
    localparam logic [SEL_W:0]  LEN_MAX  = (SEL_W + 1)'(BYTES);
    localparam bit              FR       = (FRAMED != 0);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_next;
    logic [7:0]       buffer [BYTES];
    logic [DW-1:0]    div_cnt;
    logic [2:0]       bit_cnt;
    logic [SEL_W:0]   byte_cnt;
    logic [SEL_W:0]   len_reg;
    logic [SEL_W:0]   len_eff;
    logic [7:0]       cur_byte;
    logic             tick, last_bit, last_byte, byte_end, accept, write_ok;

    assign tick      = (div_cnt == DIV_LAST);
    assign last_bit  = (bit_cnt == 3'd7);
    assign last_byte = (byte_cnt == (len_reg - (SEL_W + 1)'(1)));
    assign accept    = send && (state == IDLE);
    assign write_ok  = get && (state == IDLE) && ({1'b0, sel} < LEN_MAX);
    assign len_eff   = ((len == '0) || (len > LEN_MAX)) ? LEN_MAX : len;
    // A byte finishes after its stop bit when framed, after data bit 7 when raw.
    assign byte_end  = tick && (FR ? (state == STOP) : (state == DATA && last_bit));
    // Read combinationally so a write landing on the send edge is already visible.
    assign cur_byte  = buffer[byte_cnt[SEL_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (send) state_next = FR ? START : DATA;
            START: if (tick) state_next = DATA;
            DATA: begin
                if (tick && last_bit) begin
                    if (FR)             state_next = STOP;
                    else if (last_byte) state_next = IDLE;
                end
            end
            STOP:  if (tick) state_next = last_byte ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = (state != IDLE);
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = cur_byte[bit_cnt];
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            len_reg  <= '0;
        end else if (state == IDLE) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            if (accept) len_reg <= len_eff;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (tick && state == DATA) bit_cnt <= bit_cnt + 3'd1;
            if (byte_end) byte_cnt <= byte_cnt + (SEL_W + 1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BYTES; i++) buffer[i] <= '0;
        end else if (write_ok) begin
            buffer[sel] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            done     <= (state != IDLE) && (state_next == IDLE);
            load_err <= get && ((state != IDLE) || ({1'b0, sel} >= LEN_MAX));
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: three configurations (framed DIV=4, raw DIV=1,
// framed DIV=2) share data/sel/len; each has its own strobes, expected-bit queue and monitor.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = '0;
    logic [2:0] sel = '0;
    logic [3:0] len = '0;
    logic [2:0] get = '0;
    logic [2:0] send = '0;
    logic [2:0] tx, busy, done, load_err;

    logic       exp_q [3][$];
    logic [7:0] mem_m [3][6];
    int         exp_done [3];
    int         done_cnt [3];
    logic [2:0] prev_busy = '0;
    int         checks = 0;
    int         fails = 0;
    logic [7:0] pat [6] = '{8'h96, 8'h3A, 8'hFF, 8'h00, 8'h5C, 8'hE1};

    always #5 clk = ~clk;

    serial_frame_tx #(.BYTES(6), .SEL_W(3), .DIV(4), .FRAMED(1)) u_f4 (
        .clk(clk), .rst(rst), .data(data), .sel(sel), .get(get[0]), .len(len),
        .send(send[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]), .load_err(load_err[0]));
    serial_frame_tx #(.BYTES(6), .SEL_W(3), .DIV(1), .FRAMED(0)) u_r1 (
        .clk(clk), .rst(rst), .data(data), .sel(sel), .get(get[1]), .len(len),
        .send(send[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]), .load_err(load_err[1]));
    serial_frame_tx #(.BYTES(6), .SEL_W(3), .DIV(2), .FRAMED(1)) u_f2 (
        .clk(clk), .rst(rst), .data(data), .sel(sel), .get(get[2]), .len(len),
        .send(send[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]), .load_err(load_err[2]));

    function automatic int div_of(input int d);
        return (d == 0) ? 4 : (d == 1) ? 1 : 2;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic push_bit(input int d, input logic b);
        repeat (div_of(d)) exp_q[d].push_back(b);
    endtask

    // Hand-written frame, emitted MSB of v first.
    task automatic push_bits(input int d, input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) push_bit(d, v[i]);
    endtask

    task automatic push_model(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            if (d != 1) push_bit(d, 1'b0);
            for (int b = 0; b < 8; b++) push_bit(d, mem_m[d][i][b]);
            if (d != 1) push_bit(d, 1'b1);
        end
    endtask

    task automatic do_write(input int d, input logic [7:0] v, input logic [2:0] s, input logic exp_err);
        @(negedge clk);
        data = v; sel = s; get[d] = 1'b1;
        if (!exp_err) mem_m[d][s] = v;
        $display("write dut%0d sel=%0d data=%02h expect_err=%0d", d, s, v, exp_err);
        @(posedge clk); #1;
        get[d] = 1'b0;
        chk("load_err", d, load_err[d], exp_err);
        @(posedge clk); #1;
        chk("load_err_clear", d, load_err[d], 1'b0);
    endtask

    task automatic do_send(input int d, input logic [3:0] l, input logic accepted);
        @(negedge clk);
        len = l; send[d] = 1'b1;
        $display("send dut%0d len=%0d accepted=%0d", d, l, accepted);
        @(posedge clk); #1;
        send[d] = 1'b0;
        if (accepted) begin
            exp_done[d]++;
            chk("busy_start", d, busy[d], 1'b1);
        end
    endtask

    task automatic do_write_send(input int d, input logic [7:0] v, input logic [2:0] s, input logic [3:0] l);
        @(negedge clk);
        data = v; sel = s; get[d] = 1'b1; len = l; send[d] = 1'b1;
        mem_m[d][s] = v;
        $display("write+send dut%0d sel=%0d data=%02h len=%0d", d, s, v, l);
        @(posedge clk); #1;
        get[d] = 1'b0; send[d] = 1'b0;
        exp_done[d]++;
        chk("busy_start", d, busy[d], 1'b1);
        chk("load_err_simul", d, load_err[d], 1'b0);
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        @(negedge clk);
        while (busy[d] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++; fails++;
            $display("FAIL wait_idle dut%0d: busy still 1 expected 0 after %0d cycles", d, n);
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every busy cycle pops one expected tx value; busy falling must bring done.
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = '0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (busy[d]) begin
                    chk("done_while_busy", d, done[d], 1'b0);
                    if (exp_q[d].size() == 0) begin
                        checks++; fails++;
                        $display("FAIL extra_busy dut%0d: busy 1 expected 0 (no bits left) at %0t", d, $time);
                    end else begin
                        chk("tx_bit", d, tx[d], exp_q[d].pop_front());
                    end
                end else begin
                    if (prev_busy[d]) begin
                        chk("done_pulse", d, done[d], 1'b1);
                        chk("tx_idle", d, tx[d], 1'b1);
                        chk("frame_len_left", d, exp_q[d].size(), 0);
                    end else if (done[d]) begin
                        chk("done_spurious", d, done[d], 1'b0);
                    end
                    if (done[d]) done_cnt[d]++;
                end
                prev_busy[d] = busy[d];
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            exp_done[d] = 0;
            done_cnt[d] = 0;
            for (int i = 0; i < 6; i++) mem_m[d][i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_tx", d, tx[d], 1'b1);
            chk("rst_busy", d, busy[d], 1'b0);
            chk("rst_done", d, done[d], 1'b0);
            chk("rst_load_err", d, load_err[d], 1'b0);
        end
        rst = 1'b0;

        // Framed 0xA5, DIV=4: 0,1,0,1,0,0,1,0,1,1
        do_write(0, 8'hA5, 3'd0, 1'b0);
        push_bits(0, 16'b0101001011, 10);
        do_send(0, 4'd1, 1'b1);
        wait_idle(0);

        // Raw 0x01,0x80, DIV=1
        do_write(1, 8'h01, 3'd0, 1'b0);
        do_write(1, 8'h80, 3'd1, 1'b0);
        push_bits(1, 16'b1000000000000001, 16);
        do_send(1, 4'd2, 1'b1);
        wait_idle(1);

        // len=0 wraps to all 6 bytes; rejected write and ignored send during the frame
        for (int i = 0; i < 6; i++) do_write(2, pat[i], 3'(i), 1'b0);
        push_model(2, 6);
        do_send(2, 4'd0, 1'b1);
        do_write(2, 8'h0F, 3'd2, 1'b1);
        do_send(2, 4'd1, 1'b0);
        wait_idle(2);
        push_model(2, 6);
        do_send(2, 4'd7, 1'b1);
        wait_idle(2);

        // Out-of-range writes leave the buffer intact
        do_write(0, 8'h77, 3'd6, 1'b1);
        do_write(0, 8'h78, 3'd7, 1'b1);
        push_model(0, 6);
        do_send(0, 4'd6, 1'b1);
        wait_idle(0);

        // Write and send on the same edge: 0x3C -> 0,0,0,1,1,1,1,0,0,1
        push_bits(0, 16'b0001111001, 10);
        do_write_send(0, 8'h3C, 3'd0, 4'd1);
        wait_idle(0);

        // Asynchronous reset in the middle of two frames
        push_model(0, 6);
        do_send(0, 4'd6, 1'b1);
        push_model(1, 2);
        do_send(1, 4'd2, 1'b1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        $display("reset asserted mid-frame");
        for (int d = 0; d < 2; d++) begin
            chk("async_rst_tx", d, tx[d], 1'b1);
            chk("async_rst_busy", d, busy[d], 1'b0);
            chk("async_rst_done", d, done[d], 1'b0);
            exp_done[d]--;
            exp_q[d].delete();
        end
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 6; i++) mem_m[d][i] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Buffer cleared: byte 0 sends as framed 0x00
        push_bits(0, 16'b0000000001, 10);
        do_send(0, 4'd1, 1'b1);
        wait_idle(0);

        for (int d = 0; d < 3; d++) begin
            chk("done_count", d, done_cnt[d], exp_done[d]);
            chk("queue_empty", d, exp_q[d].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Parametrised, buffered serial transmitter for the FPGA datapath. Host logic writes up to BYTES bytes into a byte-addressed buffer, then triggers a transmission. The frame is shifted out on `tx` at a programmable bit period, either as raw LSB-first bits or as UART-style framed bytes (start/stop). Buffer contents are not destroyed by transmission, so the same frame can be resent without reloading.

## Interface
Parameters:
- BYTES, 6, buffer depth in bytes (2..16)
- SEL_W, 3, width of `sel`; must satisfy 2^SEL_W >= BYTES
- DIV, 4, clock cycles per transmitted bit (>= 1)
- FRAMED, 1, 1 = per-byte start bit (0) + 8 data + stop bit (1); 0 = raw contiguous bit stream

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- data  in  8  byte to write
- sel  in  SEL_W  buffer byte index for write
- get  in  1  write strobe: `data` into byte `sel`
- len  in  SEL_W+1  bytes to send; 0 or > BYTES means BYTES
- send  in  1  start-transmission strobe
- tx  out  1  serial line; idles high
- busy  out  1  transmission in progress
- done  out  1  one-cycle pulse at end of frame
- load_err  out  1  one-cycle pulse on a rejected write

## Operation
- Reset: buffer all 0, tx=1, busy=0, done=0, load_err=0, FSM in IDLE, all counters 0.
- Write: `get` in IDLE with sel < BYTES writes `data` into byte `sel` at that edge.
- Rejected writes, each giving load_err=1 the next cycle with the buffer unchanged:
  - `get` while busy
  - sel >= BYTES
- `send` in IDLE:
  - latches the effective length (`len`; 0 or > BYTES becomes BYTES)
  - moves the FSM to the first bit state.
- `send` while busy is ignored silently.
- FSM states:
  - IDLE: tx=1.
  - START (FRAMED=1 only): tx=0 for DIV cycles, then DATA.
  - DATA: 8 bits of the current byte, LSB first, DIV cycles each. After bit 7:
    - FRAMED=1: go to STOP.
    - FRAMED=0: go to the next byte's DATA, or to IDLE after the last byte.
  - STOP: tx=1 for DIV cycles. Then go to START of the next byte, or to IDLE after the last byte.
- Byte order: index 0 first, ascending to len-1.
- Each byte is read from the buffer when its first data bit is driven.
- Counters:
  - Divider counts 0..DIV-1 and wraps.
  - Bit counter 0..7.
  - Byte counter 0..len-1.
  - All three clear on `send` acceptance and in IDLE.
- `get` and `send` asserted in the same IDLE cycle: the write occurs and the transmission launches. The transmitted frame includes the newly written byte.
- `done` pulses for exactly 1 cycle when returning to IDLE. It never coincides with busy=1.

## Timing
- `send` sampled high at edge T:
  - busy=1 and the first bit (start bit, or data bit 0 when raw) is on tx from T+1.
  - Every bit holds for exactly DIV cycles, with no gaps between bits or bytes.
- Frame duration N cycles:
  - FRAMED=1: N = 10·len·DIV.
  - FRAMED=0: N = 8·len·DIV.
- Timing of the end of frame:
  - busy is high from T+1 to T+N.
  - At T+N+1: tx=1, busy=0, done=1.
  - A new `send` is accepted at T+N+1 at the earliest.
- DIV=1: one bit per cycle with no idle cycles inside the frame.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously), with no done pulse. The buffer is cleared.

## Test plan
- Reset values: assert rst mid-frame -> tx=1, busy=0, done=0 immediately; after release, a len=1 send of an unwritten buffer gives framed byte 0x00 (tx 0, then 8×0, then 1).
- Framed single byte: DIV=4, write 0xA5 to sel 0, len=1, send at T -> tx holds 0,1,0,1,0,0,1,0,1,1 for 4 cycles each over T+1..T+40; done=1 only at T+41.
- Raw multi-byte: FRAMED=0, DIV=1, bytes 0x01,0x80, len=2 -> tx 1,0,0,0,0,0,0,0, then 0,0,0,0,0,0,0,1 over T+1..T+16; done at T+17.
- len wrap: len=0 with BYTES=6, FRAMED=1, DIV=2 -> busy for 120 cycles, all 6 bytes sent; resend without reloading -> identical waveform.
- Rejects: get with sel=6 -> load_err pulse, buffer unchanged; get during busy -> load_err pulse, frame unaltered; send during busy -> no effect on frame or done count.
- Simultaneous get+send in IDLE: write 0x3C to sel 0 while sending len=1 -> the transmitted data bits are 0x3C (0,0,1,1,1,1,0,0).
